// File: rtl/hpm_pkg.sv
// Shared constants and types for the hardware performance-monitor counters.
package hpm_pkg;

  // CSR address bases; counter i lives at base + i.
  localparam logic [11:0] HPMCTR_BASE   = 12'hB03;
  localparam logic [11:0] HPMCTRH_BASE  = 12'hB83;
  localparam logic [11:0] HPMEVT_BASE   = 12'h323;
  localparam logic [11:0] HPMUCTR_BASE  = 12'hC03;
  localparam logic [11:0] HPMUCTRH_BASE = 12'hC83;

  // mhpmevent field positions.
  localparam int EVT_OF_BIT   = 31;
  localparam int EVT_MINH_BIT = 30;
  localparam int EVT_UINH_BIT = 29;
  localparam int EVT_OFIE_BIT = 28;
  localparam int EVT_SEL_MSB  = 7;
  localparam int EVT_SEL_LSB  = 0;

  // CSR request opcodes.
  localparam logic [1:0] CSR_OP_WRITE = 2'b01;
  localparam logic [1:0] CSR_OP_SET   = 2'b10;
  localparam logic [1:0] CSR_OP_CLEAR = 2'b11;

  // Names of the event_i bits as wired from the pipelines.
  typedef enum logic [2:0] {
    EV_CYCLE     = 3'd0,
    EV_INSTRET   = 3'd1,
    EV_LOAD      = 3'd2,
    EV_STORE     = 3'd3,
    EV_BRANCH    = 3'd4,
    EV_BR_MISS   = 3'd5,
    EV_DC_MISS   = 3'd6,
    EV_IC_MISS   = 3'd7
  } hpm_event_e;

  // New register value for a CSR operation; unknown opcodes leave it unchanged.
  function automatic logic [31:0] csr_apply_op(input logic [1:0]  op,
                                               input logic [31:0] old,
                                               input logic [31:0] data);
    logic [31:0] bit_mask;
    bit_mask = 32'd1 << data[4:0];
    case (op)
      CSR_OP_WRITE: csr_apply_op = data;
      CSR_OP_SET:   csr_apply_op = old | bit_mask;
      CSR_OP_CLEAR: csr_apply_op = old & ~bit_mask;
      default:      csr_apply_op = old;
    endcase
  endfunction

endpackage

// File: rtl/hpm_counter.sv
// One performance counter with its event-select register, privilege filter
// and sticky overflow flag.
module hpm_counter #(
  parameter int CTR_WIDTH  = 48,
  parameter int NUM_EVENTS = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_EVENTS-1:0] event_i,
  input  logic                  priv_i,
  input  logic                  wr_lo_i,
  input  logic                  wr_hi_i,
  input  logic                  wr_evt_i,
  input  logic [31:0]           wdata_i,
  output logic [63:0]           ctr_o,
  output logic [31:0]           evt_o,
  output logic                  irq_o
);
  import hpm_pkg::*;

  logic [CTR_WIDTH-1:0] ctr_q, ctr_d;
  logic                 of_q, minh_q, uinh_q, ofie_q;
  logic [7:0]           sel_q;
  logic [255:0]         ev_pad;
  logic [63:0]          ctr_ext, wr_full;
  logic [7:0]           sel_wr;
  logic                 inc, ctr_wr, wrap;
  logic                 unused_bits;

  // Event vector shifted by one so that select value 0 picks a constant zero.
  always_comb begin
    ev_pad = '0;
    ev_pad[NUM_EVENTS:1] = event_i;
  end

  assign inc    = ev_pad[sel_q] & ~(priv_i ? minh_q : uinh_q);
  assign ctr_wr = wr_lo_i | wr_hi_i;
  assign wrap   = inc & ~ctr_wr & (&ctr_q);

  // Zero-extended counter view; bits above CTR_WIDTH read as zero.
  always_comb begin
    ctr_ext = '0;
    ctr_ext[CTR_WIDTH-1:0] = ctr_q;
  end

  // A half write merges into the other half; a CSR write beats the increment.
  always_comb begin
    wr_full = wr_hi_i ? {wdata_i, ctr_ext[31:0]} : {ctr_ext[63:32], wdata_i};
    if (ctr_wr)   ctr_d = wr_full[CTR_WIDTH-1:0];
    else if (inc) ctr_d = ctr_q + CTR_WIDTH'(1);
    else          ctr_d = ctr_q;
  end

  // SEL is WARL: out-of-range selections store 0 (counting disabled).
  assign sel_wr = (wdata_i[EVT_SEL_MSB:EVT_SEL_LSB] > 8'(NUM_EVENTS)) ? 8'd0
                                                                       : wdata_i[EVT_SEL_MSB:EVT_SEL_LSB];

  // Counter and event register state; a written OF value beats a wrap.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctr_q  <= '0;
      of_q   <= 1'b0;
      minh_q <= 1'b0;
      uinh_q <= 1'b0;
      ofie_q <= 1'b0;
      sel_q  <= '0;
    end else begin
      ctr_q <= ctr_d;
      if (wr_evt_i) begin
        of_q   <= wdata_i[EVT_OF_BIT];
        minh_q <= wdata_i[EVT_MINH_BIT];
        uinh_q <= wdata_i[EVT_UINH_BIT];
        ofie_q <= wdata_i[EVT_OFIE_BIT];
        sel_q  <= sel_wr;
      end else if (wrap) begin
        of_q <= 1'b1;
      end
    end
  end

  assign ctr_o = ctr_ext;
  assign evt_o = {of_q, minh_q, uinh_q, ofie_q, 20'd0, sel_q};
  assign irq_o = of_q & ofie_q;

  assign unused_bits = ^{wr_full, wdata_i[27:8]};

endmodule

// File: rtl/hpm_counters.sv
// Performance-monitor unit: NUM_CTRS counters behind the CSR request bus,
// with address decode, access checks, read mux and a registered response.
//
// Request/response protocol: csr_valid_i is a one-cycle request pulse with no
// back-pressure; exactly one cycle later csr_done_o pulses with csr_excp_o and
// csr_data_o (the value before any write). csr_done_o is low in every other
// cycle, and a request accepted during reset produces no response.
module hpm_counters #(
  parameter int NUM_CTRS   = 4,
  parameter int CTR_WIDTH  = 48,
  parameter int NUM_EVENTS = 8
) (
  input  logic                  cpu_clock_i,
  input  logic                  cpu_reset_i,
  input  logic                  csr_valid_i,
  input  logic [11:0]           csr_address_i,
  input  logic [1:0]            csr_opcode_i,
  input  logic                  csr_wr_en_i,
  input  logic [31:0]           csr_data_i,
  input  logic                  real_privilege_i,
  input  logic [NUM_CTRS-1:0]   counteren_i,
  input  logic [NUM_EVENTS-1:0] event_i,
  output logic                  csr_done_o,
  output logic                  csr_excp_o,
  output logic [31:0]           csr_data_o,
  output logic                  overflow_irq_o
);
  import hpm_pkg::*;

  logic [63:0]         ctr_val [NUM_CTRS];
  logic [31:0]         evt_val [NUM_CTRS];
  logic [NUM_CTRS-1:0] irq_vec, hit_lo, hit_hi, hit_evt;
  logic                hit_m, hit_u, u_en, excp, commit;
  logic [31:0]         rdata, wdata;
  logic                done_q, excp_q;
  logic [31:0]         data_q;

  // Address decode and read mux over the machine and user-alias windows.
  always_comb begin
    hit_lo  = '0;
    hit_hi  = '0;
    hit_evt = '0;
    hit_m   = 1'b0;
    hit_u   = 1'b0;
    u_en    = 1'b0;
    rdata   = '0;
    for (int i = 0; i < NUM_CTRS; i++) begin
      if (csr_address_i == HPMCTR_BASE + 12'(i)) begin
        hit_lo[i] = 1'b1; hit_m = 1'b1; rdata = ctr_val[i][31:0];
      end
      if (csr_address_i == HPMCTRH_BASE + 12'(i)) begin
        hit_hi[i] = 1'b1; hit_m = 1'b1; rdata = ctr_val[i][63:32];
      end
      if (csr_address_i == HPMEVT_BASE + 12'(i)) begin
        hit_evt[i] = 1'b1; hit_m = 1'b1; rdata = evt_val[i];
      end
      if (csr_address_i == HPMUCTR_BASE + 12'(i)) begin
        hit_u = 1'b1; u_en = counteren_i[i]; rdata = ctr_val[i][31:0];
      end
      if (csr_address_i == HPMUCTRH_BASE + 12'(i)) begin
        hit_u = 1'b1; u_en = counteren_i[i]; rdata = ctr_val[i][63:32];
      end
    end
  end

  assign excp = ~(hit_m | hit_u)
              | (hit_m & ~real_privilege_i)
              | (hit_u & csr_wr_en_i)
              | (hit_u & ~real_privilege_i & ~u_en);

  assign commit = csr_valid_i & csr_wr_en_i & ~excp;
  assign wdata  = csr_apply_op(csr_opcode_i, rdata, csr_data_i);

  for (genvar g = 0; g < NUM_CTRS; g++) begin : g_ctr
    hpm_counter #(
      .CTR_WIDTH  (CTR_WIDTH),
      .NUM_EVENTS (NUM_EVENTS)
    ) u_ctr (
      .clk_i    (cpu_clock_i),
      .rst_i    (cpu_reset_i),
      .event_i  (event_i),
      .priv_i   (real_privilege_i),
      .wr_lo_i  (commit & hit_lo[g]),
      .wr_hi_i  (commit & hit_hi[g]),
      .wr_evt_i (commit & hit_evt[g]),
      .wdata_i  (wdata),
      .ctr_o    (ctr_val[g]),
      .evt_o    (evt_val[g]),
      .irq_o    (irq_vec[g])
    );
  end

  // Response register: one-cycle done pulse carrying the old value.
  always_ff @(posedge cpu_clock_i) begin
    if (cpu_reset_i) begin
      done_q <= 1'b0;
      excp_q <= 1'b0;
      data_q <= '0;
    end else begin
      done_q <= csr_valid_i;
      excp_q <= csr_valid_i & excp;
      data_q <= (csr_valid_i & ~excp) ? rdata : 32'd0;
    end
  end

  assign csr_done_o     = done_q;
  assign csr_excp_o     = excp_q;
  assign csr_data_o     = data_q;
  assign overflow_irq_o = |irq_vec;

endmodule

// File: tb/tb_hpm_counters.sv
// Bench for hpm_counters: directed scenarios plus a randomized run, all
// checked against a register-level reference model of the CSR map.
module tb_hpm_counters;
  localparam int NC = 4;
  localparam int CW = 48;
  localparam int NE = 8;
  localparam logic [63:0] CMASK = (64'd1 << CW) - 64'd1;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          cpu_reset_i = 1'b0;
  logic          csr_valid_i = 1'b0;
  logic [11:0]   csr_address_i = '0;
  logic [1:0]    csr_opcode_i = '0;
  logic          csr_wr_en_i = 1'b0;
  logic [31:0]   csr_data_i = '0;
  logic          real_privilege_i = 1'b1;
  logic [NC-1:0] counteren_i = '0;
  logic [NE-1:0] event_i = '0;
  logic          csr_done_o, csr_excp_o, overflow_irq_o;
  logic [31:0]   csr_data_o;

  hpm_counters #(.NUM_CTRS(NC), .CTR_WIDTH(CW), .NUM_EVENTS(NE)) dut (
    .cpu_clock_i      (clk),
    .cpu_reset_i      (cpu_reset_i),
    .csr_valid_i      (csr_valid_i),
    .csr_address_i    (csr_address_i),
    .csr_opcode_i     (csr_opcode_i),
    .csr_wr_en_i      (csr_wr_en_i),
    .csr_data_i       (csr_data_i),
    .real_privilege_i (real_privilege_i),
    .counteren_i      (counteren_i),
    .event_i          (event_i),
    .csr_done_o       (csr_done_o),
    .csr_excp_o       (csr_excp_o),
    .csr_data_o       (csr_data_o),
    .overflow_irq_o   (overflow_irq_o)
  );

  // ---------------- reference model ----------------
  logic [63:0] m_ctr  [NC];
  logic        m_of   [NC];
  logic        m_minh [NC];
  logic        m_uinh [NC];
  logic        m_ofie [NC];
  logic [7:0]  m_sel  [NC];

  logic          priv = 1'b1;
  logic [NC-1:0] cen = '0;

  logic [31:0] exp_q[$];
  logic        exp_done, exp_excp, exp_irq;
  logic        obs_done, obs_excp, obs_irq;
  logic [31:0] obs_data;
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic logic [31:0] m_evt_word(input int i);
    return {m_of[i], m_minh[i], m_uinh[i], m_ofie[i], 20'd0, m_sel[i]};
  endfunction

  // Advance the architectural model by one clock with the given request.
  task automatic model_step(input logic v, input logic [11:0] a, input logic [1:0] op,
                            input logic we, input logic [31:0] d, input logic [7:0] ev,
                            input logic rst);
    int kind, idx;
    logic [31:0] old, nv;
    bit ex, commit, inc;
    if (rst) begin
      for (int i = 0; i < NC; i++) begin
        m_ctr[i] = 0; m_of[i] = 0; m_minh[i] = 0; m_uinh[i] = 0; m_ofie[i] = 0; m_sel[i] = 0;
      end
      exp_done = 0; exp_excp = 0; exp_irq = 0;
      return;
    end
    kind = 0; idx = 0;
    for (int i = 0; i < NC; i++) begin
      if (a == 12'hB03 + 12'(i)) begin kind = 1; idx = i; end
      if (a == 12'hB83 + 12'(i)) begin kind = 2; idx = i; end
      if (a == 12'h323 + 12'(i)) begin kind = 3; idx = i; end
      if (a == 12'hC03 + 12'(i)) begin kind = 4; idx = i; end
      if (a == 12'hC83 + 12'(i)) begin kind = 5; idx = i; end
    end
    ex = (kind == 0) || (kind <= 3 && !priv) || (kind >= 4 && we) ||
         (kind >= 4 && !priv && !cen[idx]);
    case (kind)
      1, 4:    old = m_ctr[idx][31:0];
      2, 5:    old = m_ctr[idx][63:32];
      3:       old = m_evt_word(idx);
      default: old = 0;
    endcase
    exp_done = v;
    exp_excp = v && ex;
    if (v) exp_q.push_back(old);
    commit = v && we && !ex;
    case (op)
      2'b01:   nv = d;
      2'b10:   nv = old | (32'd1 << d[4:0]);
      2'b11:   nv = old & ~(32'd1 << d[4:0]);
      default: nv = old;
    endcase
    for (int i = 0; i < NC; i++) begin
      inc = (m_sel[i] != 0) && ev[m_sel[i] - 8'd1] && !(priv ? m_minh[i] : m_uinh[i]);
      if (commit && kind == 1 && idx == i)
        m_ctr[i] = {m_ctr[i][63:32], nv} & CMASK;
      else if (commit && kind == 2 && idx == i)
        m_ctr[i] = {nv, m_ctr[i][31:0]} & CMASK;
      else if (inc) begin
        m_ctr[i] = (m_ctr[i] + 64'd1) & CMASK;
        if (m_ctr[i] == 0) m_of[i] = 1;
      end
      if (commit && kind == 3 && idx == i) begin
        m_of[i] = nv[31]; m_minh[i] = nv[30]; m_uinh[i] = nv[29]; m_ofie[i] = nv[28];
        m_sel[i] = (nv[7:0] > 8'(NE)) ? 8'd0 : nv[7:0];
      end
    end
    exp_irq = 0;
    for (int i = 0; i < NC; i++) exp_irq = exp_irq | (m_of[i] & m_ofie[i]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [11:0] a, input logic [1:0] op,
                       input logic we, input logic [31:0] d, input logic [7:0] ev,
                       input logic rst);
    csr_valid_i = v; csr_address_i = a; csr_opcode_i = op; csr_wr_en_i = we;
    csr_data_i = d; event_i = ev; cpu_reset_i = rst;
    real_privilege_i = priv; counteren_i = cen;
    model_step(v, a, op, we, d, ev, rst);
    @(posedge clk);
    #1;
    obs_done = csr_done_o; obs_excp = csr_excp_o; obs_data = csr_data_o; obs_irq = overflow_irq_o;
    csr_valid_i = 0; csr_wr_en_i = 0; event_i = '0; cpu_reset_i = 0;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
    drive(1, a, op, 1, d, 8'd0, 0);
  endtask

  task automatic csr_read(input logic [11:0] a);
    drive(1, a, 2'b00, 0, 32'd0, 8'd0, 0);
  endtask

  task automatic idle(input logic [7:0] ev);
    drive(0, 12'd0, 2'b00, 0, 32'd0, ev, 0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    drive(0, 12'd0, 2'b00, 0, 32'd0, 8'd0, 1);
    drive(0, 12'd0, 2'b00, 0, 32'd0, 8'd0, 1);
    n_checks++;
    if (obs_done !== 1'b0 || obs_excp !== 1'b0 || obs_data !== 32'd0 || obs_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got done=%b excp=%b data=%h irq=%b expected all 0",
               obs_done, obs_excp, obs_data, obs_irq);
    end
    priv = 1;
    for (int i = 0; i < NC; i++) begin
      csr_read(12'hB03 + 12'(i));
      n_checks++;
      if (obs_data !== 32'd0) begin
        n_fail++; $display("FAIL reset_ctr%0d: got %h expected 0", i, obs_data);
      end
      csr_read(12'h323 + 12'(i));
      n_checks++;
      if (obs_data !== 32'd0) begin
        n_fail++; $display("FAIL reset_evt%0d: got %h expected 0", i, obs_data);
      end
    end
  endtask

  task automatic test_basic_count;
    priv = 1;
    csr_write(12'h323, 2'b01, 32'h0000_0001);
    for (int k = 0; k < 5; k++) idle(8'h01);
    csr_read(12'hB03);
    n_checks++;
    if (obs_done !== 1'b1 || obs_excp !== 1'b0 || obs_data !== 32'd5) begin
      n_fail++;
      $display("FAIL basic_count: got done=%b excp=%b data=%h expected 1 0 00000005",
               obs_done, obs_excp, obs_data);
    end
    idle(8'h00);
    n_checks++;
    if (obs_done !== 1'b0) begin
      n_fail++; $display("FAIL done_single_pulse: got done=%b expected 0", obs_done);
    end
  endtask

  task automatic test_overflow;
    priv = 1;
    csr_write(12'hB03, 2'b01, 32'hFFFF_FFFF);
    csr_write(12'hB83, 2'b01, 32'h0000_FFFF);
    csr_write(12'h323, 2'b01, 32'h1000_0001);
    idle(8'h01);
    n_checks++;
    if (obs_irq !== 1'b1) begin
      n_fail++; $display("FAIL overflow_irq_set: got %b expected 1", obs_irq);
    end
    csr_read(12'hB03);
    n_checks++;
    if (obs_data !== 32'd0) begin
      n_fail++; $display("FAIL overflow_lo: got %h expected 0", obs_data);
    end
    csr_read(12'hB83);
    n_checks++;
    if (obs_data !== 32'd0) begin
      n_fail++; $display("FAIL overflow_hi: got %h expected 0", obs_data);
    end
    csr_read(12'h323);
    n_checks++;
    if (obs_data !== 32'h9000_0001) begin
      n_fail++; $display("FAIL overflow_evt: got %h expected 90000001", obs_data);
    end
    csr_write(12'h323, 2'b11, 32'd31);
    n_checks++;
    if (obs_irq !== 1'b0) begin
      n_fail++; $display("FAIL overflow_irq_clear: got %b expected 0", obs_irq);
    end
  endtask

  task automatic test_privilege_filter;
    priv = 1;
    csr_write(12'hB03, 2'b01, 32'd0);
    csr_write(12'h323, 2'b01, 32'h2000_0001);
    priv = 0;
    for (int k = 0; k < 10; k++) idle(8'h01);
    priv = 1;
    csr_read(12'hB03);
    n_checks++;
    if (obs_data !== 32'd0) begin
      n_fail++; $display("FAIL uinh_filter: got %h expected 0", obs_data);
    end
    csr_write(12'h323, 2'b01, 32'h4000_0001);
    for (int k = 0; k < 10; k++) idle(8'h01);
    csr_read(12'hB03);
    n_checks++;
    if (obs_data !== 32'd0) begin
      n_fail++; $display("FAIL minh_filter: got %h expected 0", obs_data);
    end
    csr_write(12'h323, 2'b01, 32'h0000_0001);
    for (int k = 0; k < 10; k++) idle(8'h01);
    csr_read(12'hB03);
    n_checks++;
    if (obs_data !== 32'd10) begin
      n_fail++; $display("FAIL no_filter: got %h expected 0000000a", obs_data);
    end
  endtask

  task automatic test_user_access;
    priv = 0; cen = '0;
    csr_read(12'hC03);
    n_checks++;
    if (obs_excp !== 1'b1) begin
      n_fail++; $display("FAIL user_read_disabled: got excp=%b expected 1", obs_excp);
    end
    cen = 4'b0001;
    csr_read(12'hC03);
    n_checks++;
    if (obs_excp !== 1'b0 || obs_data !== 32'd10) begin
      n_fail++; $display("FAIL user_read_enabled: got excp=%b data=%h expected 0 0000000a", obs_excp, obs_data);
    end
    csr_write(12'hC03, 2'b01, 32'd7);
    n_checks++;
    if (obs_excp !== 1'b1) begin
      n_fail++; $display("FAIL user_write_alias: got excp=%b expected 1", obs_excp);
    end
    csr_read(12'hB03);
    n_checks++;
    if (obs_excp !== 1'b1) begin
      n_fail++; $display("FAIL user_read_machine: got excp=%b expected 1", obs_excp);
    end
    priv = 1; cen = '0;
    csr_write(12'hC03, 2'b01, 32'd7);
    n_checks++;
    if (obs_excp !== 1'b1) begin
      n_fail++; $display("FAIL machine_write_alias: got excp=%b expected 1", obs_excp);
    end
    csr_read(12'hB03);
    n_checks++;
    if (obs_data !== 32'd10) begin
      n_fail++; $display("FAIL alias_write_dropped: got %h expected 0000000a", obs_data);
    end
  endtask

  task automatic test_collisions;
    priv = 1;
    drive(1, 12'hB03, 2'b01, 1, 32'h0000_0100, 8'h01, 0);
    csr_read(12'hB03);
    n_checks++;
    if (obs_data !== 32'h0000_0100) begin
      n_fail++; $display("FAIL write_beats_inc: got %h expected 00000100", obs_data);
    end
    csr_write(12'h323, 2'b01, 32'h0000_00FF);
    csr_read(12'h323);
    n_checks++;
    if (obs_data !== 32'd0) begin
      n_fail++; $display("FAIL sel_warl_ff: got %h expected 0", obs_data);
    end
    csr_write(12'h323, 2'b01, 32'd9);
    csr_read(12'h323);
    n_checks++;
    if (obs_data !== 32'd0) begin
      n_fail++; $display("FAIL sel_warl_9: got %h expected 0", obs_data);
    end
    csr_write(12'h323, 2'b01, 32'd8);
    csr_read(12'h323);
    n_checks++;
    if (obs_data !== 32'd8) begin
      n_fail++; $display("FAIL sel_max: got %h expected 00000008", obs_data);
    end
    csr_read(12'hB03 + 12'(NC));
    n_checks++;
    if (obs_excp !== 1'b1) begin
      n_fail++; $display("FAIL addr_past_end: got excp=%b expected 1", obs_excp);
    end
    csr_read(12'h323 + 12'(NC));
    n_checks++;
    if (obs_excp !== 1'b1) begin
      n_fail++; $display("FAIL evt_past_end: got excp=%b expected 1", obs_excp);
    end
    csr_write(12'h323, 2'b01, 32'h1000_0001);
    csr_write(12'hB03, 2'b01, 32'hFFFF_FFFF);
    csr_write(12'hB83, 2'b01, 32'h0000_FFFF);
    drive(1, 12'h323, 2'b01, 1, 32'h1000_0001, 8'h01, 0);
    csr_read(12'h323);
    n_checks++;
    if (obs_data !== 32'h1000_0001 || obs_irq !== 1'b0) begin
      n_fail++; $display("FAIL evt_write_beats_wrap: got %h irq=%b expected 10000001 irq=0", obs_data, obs_irq);
    end
    csr_read(12'hB83);
    n_checks++;
    if (obs_data !== 32'd0) begin
      n_fail++; $display("FAIL wrap_with_evt_write: got %h expected 0", obs_data);
    end
  endtask

  task automatic test_reset_mid_request;
    priv = 1;
    csr_write(12'h323, 2'b01, 32'h1000_0001);
    csr_write(12'hB03, 2'b01, 32'd0);
    for (int k = 0; k < 7; k++) idle(8'h01);
    drive(1, 12'hB03, 2'b01, 1, 32'h0000_0055, 8'h01, 1);
    n_checks++;
    if (obs_done !== 1'b0 || obs_irq !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_request: got done=%b irq=%b expected 0 0", obs_done, obs_irq);
    end
    for (int i = 0; i < NC; i++) begin
      csr_read(12'hB03 + 12'(i));
      n_checks++;
      if (obs_data !== 32'd0) begin
        n_fail++; $display("FAIL reset_mid_lo%0d: got %h expected 0", i, obs_data);
      end
      csr_read(12'h323 + 12'(i));
      n_checks++;
      if (obs_data !== 32'd0) begin
        n_fail++; $display("FAIL reset_mid_evt%0d: got %h expected 0", i, obs_data);
      end
    end
  endtask

  task automatic test_random;
    logic [11:0] addrs [25];
    logic [11:0] a;
    logic [31:0] d, exp_data;
    logic we, v;
    for (int i = 0; i < NC; i++) begin
      addrs[i]        = 12'hB03 + 12'(i);
      addrs[NC + i]   = 12'hB83 + 12'(i);
      addrs[2*NC + i] = 12'h323 + 12'(i);
      addrs[3*NC + i] = 12'hC03 + 12'(i);
      addrs[4*NC + i] = 12'hC83 + 12'(i);
    end
    addrs[20] = 12'hB07; addrs[21] = 12'hC87; addrs[22] = 12'h327;
    addrs[23] = 12'h000; addrs[24] = 12'h322;
    exp_q.delete();
    for (int k = 0; k < 600; k++) begin
      priv = ($urandom_range(0, 3) != 0);
      cen  = NC'($urandom_range(0, 15));
      v    = $urandom_range(0, 1);
      we   = ($urandom_range(0, 2) == 0);
      a    = addrs[$urandom_range(0, 24)];
      d    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      drive(v, a, 2'($urandom_range(1, 3)), we, d, 8'($urandom_range(0, 255)), 0);
      n_checks++;
      if (obs_done !== exp_done || obs_irq !== exp_irq) begin
        n_fail++;
        $display("FAIL rand_done_irq[%0d]: got done=%b irq=%b expected %b %b",
                 k, obs_done, obs_irq, exp_done, exp_irq);
      end
      if (exp_done) begin
        exp_data = exp_q.pop_front();
        n_checks++;
        if (obs_excp !== exp_excp) begin
          n_fail++;
          $display("FAIL rand_excp[%0d] addr=%h: got %b expected %b", k, a, obs_excp, exp_excp);
        end else if (!exp_excp) begin
          n_checks++;
          if (obs_data !== exp_data) begin
            n_fail++;
            $display("FAIL rand_data[%0d] addr=%h: got %h expected %h", k, a, obs_data, exp_data);
          end
        end
      end
    end
    priv = 1;
    for (int i = 0; i < NC; i++) begin
      csr_read(12'hB83 + 12'(i));
      exp_data = exp_q.pop_front();
      n_checks++;
      if (obs_data !== exp_data) begin
        n_fail++; $display("FAIL rand_final_hi%0d: got %h expected %h", i, obs_data, exp_data);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic_count();
    test_overflow();
    test_privilege_filter();
    test_user_access();
    test_collisions();
    test_reset_mid_request();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
